store_monitor: RTL and testbench

Memory-mapped store monitor on the single-cycle RISC-V core's data-memory write port (MemWrite, DataAdr, WriteData). It is the consuming end of that interface in synthesizable form. It captures every store inside a configurable address window into a first-word-fall-through FIFO, drained over a valid/ready stream. It also latches a done/pass verdict from the store to the completion mailbox: address 100, pass value 25. This lets FPGA builds and benches report program completion without simulator-only checks.

---
 rtl/store_monitor.sv | 94 +++++++++
 tb/tb_store_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// store_monitor: captures core stores inside an address window into a FWFT FIFO
// drained over valid/ready, and latches the done/pass verdict from the completion mailbox.
module store_monitor #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] WIN_LO   = 32'h0000_0000,
    parameter logic [31:0] WIN_HI   = 32'hFFFF_FFFF,
    parameter logic [31:0] DONE_ADR = 32'd100,
    parameter logic [31:0] PASS_VAL = 32'd25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     misaligned,
    output logic                     done,
    output logic                     pass
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          overflow_q, overflow_d, misaligned_q, misaligned_d;
    logic          done_q, done_d, pass_q, pass_d;
    logic [32:0]   lo_diff, hi_diff;
    logic          capture, full, pop, push, drop, mbox;
    // Window bounds via 33-bit borrow so a full-range window needs no constant compares
    assign lo_diff = {1'b0, DataAdr} - {1'b0, WIN_LO};
    assign hi_diff = {1'b0, WIN_HI} - {1'b0, DataAdr};
    always_comb begin
        capture      = MemWrite && !lo_diff[32] && !hi_diff[32];
        full         = count_q == CW'(DEPTH);
        pop          = (count_q != '0) && out_ready;
        push         = capture && (!full || pop);
        drop         = capture && full && !pop;
        mbox         = MemWrite && (DataAdr == DONE_ADR) && !done_q;
        wr_d         = push ? wr_q + AW'(1) : wr_q;
        rd_d         = pop ? rd_q + AW'(1) : rd_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        overflow_d   = overflow_q || drop;
        drop_d       = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        misaligned_d = misaligned_q || (capture && DataAdr[1:0] != 2'b00);
        done_d       = done_q || mbox;
        pass_d       = mbox ? (WriteData == PASS_VAL) : pass_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            drop_q       <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_q] <= DataAdr;
                data_q[wr_q] <= WriteData;
            end
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            overflow_q   <= overflow_d;
            misaligned_q <= misaligned_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end
    assign out_valid  = count_q != '0;
    assign out_addr   = addr_q[rd_q];
    assign out_data   = data_q[rd_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_q;
    assign misaligned = misaligned_q;
    assign done       = done_q;
    assign pass       = pass_q;
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: scoreboard bench for store_monitor; a full-range instance plus
// a windowed instance (64..127, always ready) share the store stimulus.
module tb_store_monitor;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, out_ready = 1'b0, w_ready = 1'b1;
    logic [31:0] DataAdr = '0, WriteData = '0;
    logic        out_valid, overflow, misaligned, done, pass;
    logic [31:0] out_addr, out_data;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        w_valid, w_overflow, w_misaligned, w_done, w_pass;
    logic [31:0] w_addr, w_data;
    logic [3:0]  w_count;
    logic [7:0]  w_drop;

    ent_t q[$], qw[$];
    ent_t em, ew;
    int   checks = 0, errors = 0, w_pops = 0;

    store_monitor u_dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .misaligned(misaligned),
        .done(done), .pass(pass)
    );

    store_monitor #(.WIN_LO(32'd64), .WIN_HI(32'd127)) u_win (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .out_valid(w_valid), .out_ready(w_ready), .out_addr(w_addr), .out_data(w_data),
        .count(w_count), .overflow(w_overflow), .drop_cnt(w_drop), .misaligned(w_misaligned),
        .done(w_done), .pass(w_pass)
    );

    always #5 clk = ~clk;

    // One cycle: score any handshake at the falling edge, then return 1 time unit after the rising edge
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL main_pop: got %h/%h, expected no entry", out_addr, out_data);
                end else begin
                    em = q.pop_front();
                    if ({out_addr, out_data} !== em) begin
                        errors++;
                        $display("FAIL main_pop: got %h/%h, expected %h/%h", out_addr, out_data, em.a, em.d);
                    end
                end
            end
            if (w_valid && w_ready) begin
                checks++;
                w_pops++;
                if (qw.size() == 0) begin
                    errors++;
                    $display("FAIL win_pop: got %h/%h, expected no entry", w_addr, w_data);
                end else begin
                    ew = qw.pop_front();
                    if ({w_addr, w_data} !== ew) begin
                        errors++;
                        $display("FAIL win_pop: got %h/%h, expected %h/%h", w_addr, w_data, ew.a, ew.d);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input bit p);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        if (p) q.push_back('{a: a, d: d});
        if (a >= 32'd64 && a <= 32'd127) qw.push_back('{a: a, d: d});
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        qw.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (count == 0 && w_count == 0) break;
            tick();
        end
        checks++;
        if (count !== 4'd0 || q.size() != 0) begin
            errors++;
            $display("FAIL drain: count=%0d left=%0d, expected 0/0", count, q.size());
        end
        checks++;
        if (w_count !== 4'd0 || qw.size() != 0) begin
            errors++;
            $display("FAIL drain_win: count=%0d left=%0d, expected 0/0", w_count, qw.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({count, out_valid, overflow, drop_cnt, misaligned, done, pass} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: count=%0d v=%b ov=%b drop=%0d mis=%b done=%b pass=%b, expected all 0",
                     count, out_valid, overflow, drop_cnt, misaligned, done, pass);
        end
        checks++;
        if (out_addr !== 32'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_head: got %h/%h, expected 0/0", out_addr, out_data);
        end
    endtask

    task automatic test_mailbox_pass();
        do_reset();
        out_ready = 1'b1;
        st(32'd96, 32'd7, 1'b1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL store96_done: got %b, expected 0", done);
        end
        st(32'd100, 32'd25, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL mailbox_pass: done=%b pass=%b, expected 1/1", done, pass);
        end
        drain();
    endtask

    task automatic test_mailbox_fail();
        do_reset();
        out_ready = 1'b1;
        st(32'd100, 32'd24, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL mailbox_fail: done=%b pass=%b, expected 1/0", done, pass);
        end
        st(32'd100, 32'd25, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL mailbox_sticky: done=%b pass=%b, expected 1/0", done, pass);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) st(32'h200 + 4 * i, 32'(i + 1), i < 8);
        checks++;
        if (count !== 4'd8 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: count=%0d v=%b, expected 8/1", count, out_valid);
        end
        checks++;
        if (drop_cnt !== 8'd2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: drop=%0d ov=%b, expected 2/1", drop_cnt, overflow);
        end
        checks++;
        if (out_addr !== 32'h200 || out_data !== 32'd1) begin
            errors++;
            $display("FAIL ovf_head: got %h/%h, expected 00000200/00000001", out_addr, out_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) st(32'h300 + 4 * i, 32'(100 + i), 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            st(32'h400 + 4 * i, 32'(200 + i), 1'b1);
            checks++;
            if (count !== 4'd8) begin
                errors++;
                $display("FAIL b2b_count: cycle %0d count=%0d, expected 8", i, count);
            end
        end
        checks++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop: drop=%0d ov=%b, expected 0/0", drop_cnt, overflow);
        end
        drain();
    endtask

    task automatic test_window();
        do_reset();
        out_ready = 1'b1;
        w_pops = 0;
        st(32'd60, 32'd1, 1'b1);
        st(32'd64, 32'd2, 1'b1);
        checks++;
        if (w_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL win_mis_early: got %b, expected 0", w_misaligned);
        end
        st(32'd127, 32'd3, 1'b1);
        st(32'd128, 32'd4, 1'b1);
        st(32'd101, 32'd5, 1'b1);
        drain();
        checks++;
        if (w_pops != 3) begin
            errors++;
            $display("FAIL win_captures: got %0d, expected 3", w_pops);
        end
        checks++;
        if (w_misaligned !== 1'b1 || w_done !== 1'b0) begin
            errors++;
            $display("FAIL win_flags: mis=%b done=%b, expected 1/0", w_misaligned, w_done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        st(32'd100, 32'd25, 1'b1);
        st(32'h101, 32'd2, 1'b1);
        st(32'h108, 32'd3, 1'b1);
        st(32'h10C, 32'd4, 1'b1);
        st(32'h110, 32'd5, 1'b1);
        checks++;
        if (count !== 4'd5 || done !== 1'b1 || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: count=%0d done=%b mis=%b, expected 5/1/1", count, done, misaligned);
        end
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'h500;
        WriteData = 32'd9;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        q.delete();
        qw.delete();
        checks++;
        if ({count, out_valid, overflow, drop_cnt, misaligned, done, pass} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d v=%b ov=%b drop=%0d mis=%b done=%b pass=%b, expected all 0",
                     count, out_valid, overflow, drop_cnt, misaligned, done, pass);
        end
        tick();
        tick();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_nocap: count=%0d v=%b, expected 0/0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_mailbox_pass();
        test_mailbox_fail();
        test_overflow();
        test_back_to_back();
        test_window();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
